delay_step_scheduler: RTL

//  Sequences and arbitrates step commands to the up/down preloadable delay counter.

---
 rtl/delay_step_pkg.sv | 26 ++
 rtl/dwell_timer.sv | 26 ++
 rtl/delay_step_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/delay_step_pkg.sv
// Shared state/step types and limit arithmetic for the delay step scheduler.
package delay_step_pkg;

    typedef enum logic [1:0] {IDLE, STEP, DWELL, DONE} state_t;
    typedef enum logic [1:0] {NONE, UP, DN, RST} step_kind_t;

    localparam int MAX_WIDTH = 32;
    localparam int STEPS_W   = 16;

    // One bit wider than the operands so value+increment and min+increment never wrap.
    function automatic logic step_allowed(
        input step_kind_t             kind,
        input logic [MAX_WIDTH-1:0]   val,
        input logic [MAX_WIDTH-1:0]   inc,
        input logic [MAX_WIDTH-1:0]   lim
    );
        logic ok;
        case (kind)
            UP:      ok = ({1'b0, val} + {1'b0, inc}) <= {1'b0, lim};
            DN:      ok = {1'b0, val} >= ({1'b0, lim} + {1'b0, inc});
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded count.
module dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_value,
    output logic               expire
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign expire = (count == DWELL_W'(1));

endmodule

// File: rtl/delay_step_scheduler.sv
// Arbitrates manual and scan-engine step requests for the up/down delay counter.
// Define SCAN_WRAP_EN to make a limit-refused scan step reload the counter and keep scanning.
module delay_step_scheduler
    import delay_step_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_dn,
    input  logic               btn_rst,
    input  logic               scan_start,
    input  logic               scan_abort,
    input  logic               scan_dir,
    input  logic [STEPS_W-1:0] scan_steps,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [WIDTH-1:0]   preload,
    input  logic [WIDTH-1:0]   increment,
    input  logic [WIDTH-1:0]   min_val,
    input  logic [WIDTH-1:0]   max_val,
    output logic               cnt_up,
    output logic               cnt_dn,
    output logic               cnt_rst,
    output logic [WIDTH-1:0]   value,
    output logic               busy,
    output logic               done,
    output logic               limit_hit
);

    state_t             state, state_next;
    step_kind_t         kind_next, scan_kind;
    logic [STEPS_W-1:0] remaining, remaining_next;
    logic [WIDTH-1:0]   value_next, value_up, value_dn;
    logic [DWELL_W-1:0] dwell_lat, dwell_eff;
    logic               dir_lat;
    logic               done_next, limit_next, timer_load, latch_scan, end_scan;
    logic               scan_active, up_ok, dn_ok, scan_ok, timer_expire;

    assign scan_active = (state == STEP) || (state == DWELL);
    assign scan_kind   = dir_lat ? UP : DN;
    assign up_ok       = step_allowed(UP, MAX_WIDTH'(value), MAX_WIDTH'(increment), MAX_WIDTH'(max_val));
    assign dn_ok       = step_allowed(DN, MAX_WIDTH'(value), MAX_WIDTH'(increment), MAX_WIDTH'(min_val));
    assign scan_ok     = dir_lat ? up_ok : dn_ok;
    assign value_up    = value + increment;
    assign value_dn    = value - increment;
    assign dwell_eff   = (dwell_lat == '0) ? DWELL_W'(1) : dwell_lat;

    dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (dwell_eff),
        .expire     (timer_expire)
    );

    // One action per cycle, highest priority first: reload, abort, scan step, manual up/down, scan start.
    always_comb begin
        state_next     = (state == DONE) ? IDLE : state;
        remaining_next = remaining;
        value_next     = value;
        kind_next      = NONE;
        done_next      = 1'b0;
        limit_next     = 1'b0;
        timer_load     = 1'b0;
        latch_scan     = 1'b0;
        end_scan       = 1'b0;

        if (btn_rst) begin
            kind_next  = RST;
            value_next = preload;
            if (scan_active) begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
        end else if (scan_abort && scan_active) begin
            done_next  = 1'b1;
            state_next = DONE;
        end else if (state == STEP) begin
            remaining_next = remaining - STEPS_W'(1);
            if (scan_ok) begin
                kind_next  = scan_kind;
                value_next = dir_lat ? value_up : value_dn;
            end else begin
                limit_next = 1'b1;
`ifdef SCAN_WRAP_EN
                kind_next  = RST;
                value_next = preload;
`else
                end_scan   = 1'b1;
`endif
            end
            if (remaining == STEPS_W'(1)) begin
                end_scan = 1'b1;
            end
            if (end_scan) begin
                done_next  = 1'b1;
                state_next = DONE;
            end else begin
                timer_load = 1'b1;
                state_next = DWELL;
            end
        end else if (scan_active) begin
            if (timer_expire) begin
                state_next = STEP;
            end
        end else if (btn_up) begin
            if (up_ok) begin
                kind_next  = UP;
                value_next = value_up;
            end else begin
                limit_next = 1'b1;
            end
        end else if (btn_dn) begin
            if (dn_ok) begin
                kind_next  = DN;
                value_next = value_dn;
            end else begin
                limit_next = 1'b1;
            end
        end else if (scan_start && (state == IDLE)) begin
            if (scan_steps == '0) begin
                done_next = 1'b1;
            end else begin
                latch_scan     = 1'b1;
                remaining_next = scan_steps;
                state_next     = STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            dir_lat   <= 1'b0;
            dwell_lat <= '0;
            value     <= preload;
            cnt_up    <= 1'b0;
            cnt_dn    <= 1'b0;
            cnt_rst   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            limit_hit <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            value     <= value_next;
            cnt_up    <= (kind_next == UP);
            cnt_dn    <= (kind_next == DN);
            cnt_rst   <= (kind_next == RST);
            busy      <= (state_next == STEP) || (state_next == DWELL);
            done      <= done_next;
            limit_hit <= limit_next;
            if (latch_scan) begin
                dir_lat   <= scan_dir;
                dwell_lat <= dwell;
            end
        end
    end

endmodule
